// File: rtl/mem_writeback.sv
// mem_writeback: final pipeline stage. Registers the execute result, runs
// data-memory loads/stores over a valid/ready request + response interface,
// aligns/extends load data and drives the register-file write port, which
// doubles as the forwarding source back to execute.
// Optional feature macro: MISALIGN_CHECK_EN (adds the misaligned port and
// suppresses misaligned half/word accesses).
module mem_writeback #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_we,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  output logic        stall,
  output logic [31:0] previous,
  output logic [4:0]  prev_rd,
  output logic        prev_reg_we,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_rdata
`ifdef MISALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  acc_off;
  logic [2:0]  acc_f3;
  logic [4:0]  acc_rd;
  logic        mem_op;
  logic        bad_align;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign mem_op = ex_mem_read | ex_mem_write;
  assign stall  = (state != IDLE);

`ifdef MISALIGN_CHECK_EN
  // Halves must be 2-byte aligned, words 4-byte aligned.
  always_comb begin
    bad_align = 1'b0;
    case (ex_funct3[1:0])
      2'b01:   bad_align = ex_result[0];
      2'b10:   bad_align = |ex_result[1:0];
      default: bad_align = 1'b0;
    endcase
  end
`else
  // Without the check, low address bits below the access size are ignored.
  assign bad_align = 1'b0;
`endif

  // Store lane replication and byte enables from size and low address bits.
  always_comb begin
    st_data = ex_store_data;
    st_mask = 4'b1111;
    case (ex_funct3[1:0])
      2'b00: begin
        st_data = {4{ex_store_data[7:0]}};
        st_mask = 4'b0001 << ex_result[1:0];
      end
      2'b01: begin
        st_data = {2{ex_store_data[15:0]}};
        st_mask = ex_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = ex_store_data;
        st_mask = 4'b1111;
      end
    endcase
  end

  // Load lane select and sign/zero extension; funct3[2] marks unsigned.
  always_comb begin
    ld_byte = dmem_resp_rdata[8*acc_off +: 8];
    ld_half = acc_off[1] ? dmem_resp_rdata[31:16] : dmem_resp_rdata[15:0];
    case (acc_f3[1:0])
      2'b00:   ld_data = {{24{ld_byte[7] & ~acc_f3[2]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~acc_f3[2]}}, ld_half};
      default: ld_data = dmem_resp_rdata;
    endcase
  end

  // Next-state logic for the memory access sequencer.
  always_comb begin
    state_nxt      = state;
    dmem_req_valid = 1'b0;
    case (state)
      IDLE: if (ex_valid && mem_op && !bad_align) state_nxt = REQ;
      REQ: begin
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) state_nxt = dmem_we ? IDLE : RESP;
      end
      RESP:    if (dmem_resp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Writeback/forwarding registers and latched request fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      previous    <= '0;
      prev_rd     <= '0;
      prev_reg_we <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_wmask  <= '0;
      dmem_we     <= 1'b0;
      acc_off     <= '0;
      acc_f3      <= '0;
      acc_rd      <= '0;
`ifdef MISALIGN_CHECK_EN
      misaligned  <= 1'b0;
`endif
    end else begin
`ifdef MISALIGN_CHECK_EN
      misaligned <= 1'b0;
`endif
      case (state)
        IDLE: begin
          prev_reg_we <= 1'b0;
          if (ex_valid && !mem_op) begin
            previous    <= ex_result;
            prev_rd     <= ex_rd;
            prev_reg_we <= ex_reg_we & (ex_rd != 5'd0);
          end else if (ex_valid && mem_op) begin
            if (bad_align) begin
`ifdef MISALIGN_CHECK_EN
              misaligned <= 1'b1;
`endif
            end else begin
              dmem_addr  <= {ex_result[31:2], 2'b00};
              dmem_we    <= ex_mem_write;
              dmem_wdata <= st_data;
              dmem_wmask <= ex_mem_write ? st_mask : 4'b0000;
              acc_off    <= ex_result[1:0];
              acc_f3     <= ex_funct3;
              acc_rd     <= ex_rd;
            end
          end
        end
        REQ:  prev_reg_we <= 1'b0;
        RESP: begin
          prev_reg_we <= 1'b0;
          if (dmem_resp_valid) begin
            previous    <= ld_data;
            prev_rd     <= acc_rd;
            prev_reg_we <= (acc_rd != 5'd0);
          end
        end
        default: prev_reg_we <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Directed bench for mem_writeback: ALU writeback, rd=0, idle, byte/half/word
// loads, a back-pressured halfword store, reset mid-access and the
// misaligned-access behaviour (either build).
module tb_mem_writeback;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_reg_we, ex_mem_read, ex_mem_write;
  logic [31:0] ex_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        stall, prev_reg_we, dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] previous, dmem_addr, dmem_wdata, dmem_resp_rdata;
  logic [4:0]  prev_rd;
  logic [3:0]  dmem_wmask;
  logic        dmem_resp_valid;
`ifdef MISALIGN_CHECK_EN
  logic        misaligned;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_writeback dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .stall(stall), .previous(previous), .prev_rd(prev_rd), .prev_reg_we(prev_reg_we),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata)
`ifdef MISALIGN_CHECK_EN
    , .misaligned(misaligned)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd_, input logic wr_, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_mem_read = rd_; ex_mem_write = wr_; ex_funct3 = f3;
    ex_result = addr; ex_store_data = sd; ex_rd = rd; ex_reg_we = rd_;
    tick();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 0; ex_reg_we = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_result = 0; ex_store_data = 0; ex_rd = 0; ex_funct3 = 0;
    dmem_req_ready = 0; dmem_resp_valid = 0; dmem_resp_rdata = 0;
    tick(); tick();
    chk("rst_stall", stall, 0);
    chk("rst_prev", previous, 0);
    chk("rst_we", prev_reg_we, 0);
    chk("rst_reqv", dmem_req_valid, 0);
    chk("rst_wmask", dmem_wmask, 0);
    chk("rst_addr", dmem_addr, 0);
    rst_n = 1'b1;
    tick();

    // ALU op
    ex_valid = 1; ex_result = 32'h1234; ex_rd = 5; ex_reg_we = 1;
    tick();
    chk("alu_prev", previous, 32'h1234);
    chk("alu_rd", prev_rd, 5);
    chk("alu_we", prev_reg_we, 1);
    chk("alu_stall", stall, 0);
    // rd=0 write
    ex_result = 32'h55; ex_rd = 0;
    tick();
    chk("rd0_we", prev_reg_we, 0);
    chk("rd0_prev", previous, 32'h55);
    // idle: previous holds
    ex_valid = 0;
    tick();
    chk("idle_we", prev_reg_we, 0);
    chk("idle_prev", previous, 32'h55);

    // lb at 0x103
    dmem_req_ready = 1;
    issue(1, 0, 3'b000, 32'h103, 0, 7);
    chk("lb_stall_req", stall, 1);
    chk("lb_reqv", dmem_req_valid, 1);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_we", dmem_we, 0);
    chk("lb_fwd_off", prev_reg_we, 0);
    tick();
    chk("lb_stall_resp", stall, 1);
    chk("lb_reqv_drop", dmem_req_valid, 0);
    dmem_resp_valid = 1; dmem_resp_rdata = 32'h80FF_0000;
    tick();
    dmem_resp_valid = 0;
    chk("lb_data", previous, 32'hFFFF_FF80);
    chk("lb_rd", prev_rd, 7);
    chk("lb_rf_we", prev_reg_we, 1);
    chk("lb_stall_end", stall, 0);

    // stray response in IDLE ignored
    dmem_resp_valid = 1; dmem_resp_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_resp_valid = 0;
    chk("stray_prev", previous, 32'hFFFF_FF80);
    chk("stray_we", prev_reg_we, 0);

    // lhu at 0x102 -> upper half, zero-extended
    issue(1, 0, 3'b101, 32'h102, 0, 3);
    tick();
    dmem_resp_valid = 1; dmem_resp_rdata = 32'h80FF_0000;
    tick();
    dmem_resp_valid = 0;
    chk("lhu_data", previous, 32'h0000_80FF);
    // lh at 0x100 -> lower half sign-extended
    issue(1, 0, 3'b001, 32'h100, 0, 3);
    tick();
    dmem_resp_valid = 1; dmem_resp_rdata = 32'h1234_9ABC;
    tick();
    dmem_resp_valid = 0;
    chk("lh_data", previous, 32'hFFFF_9ABC);
    // lbu at 0x101
    issue(1, 0, 3'b100, 32'h101, 0, 4);
    tick();
    dmem_resp_valid = 1; dmem_resp_rdata = 32'h1234_9ABC;
    tick();
    dmem_resp_valid = 0;
    chk("lbu_data", previous, 32'h0000_009A);

    // sh at 0x202 with 3 cycles of back-pressure
    dmem_req_ready = 0;
    issue(0, 1, 3'b001, 32'h202, 32'hABCD_5678, 9);
    for (int i = 0; i < 3; i++) begin
      chk("sh_reqv", dmem_req_valid, 1);
      chk("sh_addr", dmem_addr, 32'h200);
      chk("sh_wdata", dmem_wdata, 32'h5678_5678);
      chk("sh_wmask", dmem_wmask, 4'b1100);
      chk("sh_we", dmem_we, 1);
      chk("sh_stall", stall, 1);
      tick();
    end
    dmem_req_ready = 1;
    tick();
    chk("sh_idle", stall, 0);
    chk("sh_reqv_drop", dmem_req_valid, 0);
    chk("sh_no_rf", prev_reg_we, 0);

    // sb at 0x301 -> byte replicated, mask lane 1
    dmem_req_ready = 0;
    issue(0, 1, 3'b000, 32'h301, 32'h0000_00A5, 0);
    chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    chk("sb_wmask", dmem_wmask, 4'b0010);
    dmem_req_ready = 1;
    tick();
    chk("sb_idle", stall, 0);

    // reset while in RESP, then a late response
    issue(1, 0, 3'b010, 32'h400, 0, 9);
    tick();
    chk("rr_stall", stall, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    dmem_resp_valid = 1; dmem_resp_rdata = 32'hCAFE_F00D;
    tick();
    dmem_resp_valid = 0;
    chk("rr_stall_after", stall, 0);
    chk("rr_we", prev_reg_we, 0);
    chk("rr_prev", previous, 0);

    // lw at 0x301
    issue(1, 0, 3'b010, 32'h301, 0, 6);
`ifdef MISALIGN_CHECK_EN
    chk("mis_flag", misaligned, 1);
    chk("mis_reqv", dmem_req_valid, 0);
    chk("mis_stall", stall, 0);
    chk("mis_we", prev_reg_we, 0);
    tick();
    chk("mis_pulse", misaligned, 0);
    chk("mis_reqv2", dmem_req_valid, 0);
`else
    chk("lwmis_addr", dmem_addr, 32'h300);
    chk("lwmis_reqv", dmem_req_valid, 1);
    tick();
    dmem_resp_valid = 1; dmem_resp_rdata = 32'h1122_3344;
    tick();
    dmem_resp_valid = 0;
    chk("lwmis_data", previous, 32'h1122_3344);
    chk("lwmis_we", prev_reg_we, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
